// File: rtl/bp_fe_ras_pkg.sv
// Shared constants and link-address helper for the front-end return address stack.
package bp_fe_ras_pkg;

    localparam int ras_vaddr_width_gp = 39;
    localparam int ras_els_gp         = 8;

    // A call's return point is the next sequential instruction: +2 for RVC, +4 otherwise.
    function automatic logic [2:0] ras_link_inc(input logic compressed);
        return compressed ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/bp_fe_ras_mem.sv
// Entry storage for the return address stack: asynchronous read, synchronous write.
// Latency: read is combinational, a write lands at the next rising edge.
// Backpressure: none; a write is accepted on any cycle w_v is high.
module bp_fe_ras_mem #(
    parameter int els_p   = 8,
    parameter int width_p = 39,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v,
    input  logic [addr_width_lp-1:0] w_addr,
    input  logic [width_p-1:0]       w_data,
    input  logic [addr_width_lp-1:0] r_addr,
    output logic [width_p-1:0]       r_data
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/bp_fe_ras.sv
// Return address stack: pushes link addresses on calls, predicts targets on returns, checkpoint/restore of pointers.
// Latency: push/pop/restore visible on outputs one cycle after the edge that applies them; no bypass.
// Backpressure: none; every scan and restore is consumed in the cycle it is presented.
module bp_fe_ras
    import bp_fe_ras_pkg::*;
#(
    parameter int vaddr_width_p = ras_vaddr_width_gp,
    parameter int ras_els_p     = ras_els_gp,
    localparam int ptr_width_lp  = $clog2(ras_els_p),
    localparam int cnt_width_lp  = $clog2(ras_els_p + 1),
    localparam int ckpt_width_lp = cnt_width_lp + ptr_width_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     scan_v_i,
    input  logic                     call_i,
    input  logic                     ret_i,
    input  logic                     compressed_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    output logic                     ret_v_o,
    output logic [vaddr_width_p-1:0] ret_addr_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,
    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i
);

    typedef struct packed {
        logic [cnt_width_lp-1:0] cnt;
        logic [ptr_width_lp-1:0] tos;
    } ckpt_s;

    localparam logic [cnt_width_lp-1:0] full_cnt = cnt_width_lp'(ras_els_p);
    localparam logic [ptr_width_lp-1:0] tos_rst  = ptr_width_lp'(ras_els_p - 1);

    logic [ptr_width_lp-1:0]  tos_r, tos_n;
    logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
    logic                     empty;
    logic                     push, pop, swap;
    logic                     w_v;
    logic [ptr_width_lp-1:0]  w_addr;
    logic [vaddr_width_p-1:0] link;
    ckpt_s                    rst_ckpt;

    assign empty    = (cnt_r == '0);
    assign link     = pc_i + vaddr_width_p'(ras_link_inc(compressed_i));
    assign rst_ckpt = restore_ckpt_i;

    // A call+ret on an empty stack has nothing to pop, so it degrades to a plain push.
    assign push = scan_v_i & call_i & (~ret_i | empty);
    assign swap = scan_v_i & call_i & ret_i & ~empty;
    assign pop  = scan_v_i & ret_i & ~call_i & ~empty;

    always_comb begin
        tos_n  = tos_r;
        cnt_n  = cnt_r;
        w_v    = 1'b0;
        w_addr = tos_r;
        if (restore_v_i) begin
            tos_n = rst_ckpt.tos;
            cnt_n = rst_ckpt.cnt;
        end else if (push) begin
            w_v    = 1'b1;
            w_addr = tos_r + 1'b1;
            tos_n  = tos_r + 1'b1;
            cnt_n  = (cnt_r == full_cnt) ? cnt_r : cnt_r + 1'b1;
        end else if (swap) begin
            w_v = 1'b1;
        end else if (pop) begin
            tos_n = tos_r - 1'b1;
            cnt_n = cnt_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tos_r <= tos_rst;
            cnt_r <= '0;
        end else begin
            tos_r <= tos_n;
            cnt_r <= cnt_n;
        end
    end

    bp_fe_ras_mem #(
        .els_p   (ras_els_p),
        .width_p (vaddr_width_p)
    ) entries (
        .clk_i  (clk_i),
        .w_v    (w_v & ~reset_i),
        .w_addr (w_addr),
        .w_data (link),
        .r_addr (tos_r),
        .r_data (ret_addr_o)
    );

    assign ret_v_o = ~empty;
    assign ckpt_o  = ckpt_s'{cnt: cnt_r, tos: tos_r};

endmodule

// File: tb/tb_bp_fe_ras.sv
// Randomized and directed checks of bp_fe_ras against a behavioural stack model.
module tb_bp_fe_ras;

    localparam int VW  = 39;
    localparam int ELS = 8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          scan_v_i = 1'b0, call_i = 1'b0, ret_i = 1'b0, compressed_i = 1'b0;
    logic [VW-1:0] pc_i = '0;
    logic          ret_v_o;
    logic [VW-1:0] ret_addr_o;
    logic [6:0]    ckpt_o;
    logic          restore_v_i = 1'b0;
    logic [6:0]    restore_ckpt_i = '0;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: circular array of ELS slots, integer top index and occupancy.
    logic [VW-1:0] m_mem [ELS];
    int            m_tos = ELS - 1;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    bp_fe_ras dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .scan_v_i       (scan_v_i),
        .call_i         (call_i),
        .ret_i          (ret_i),
        .compressed_i   (compressed_i),
        .pc_i           (pc_i),
        .ret_v_o        (ret_v_o),
        .ret_addr_o     (ret_addr_o),
        .ckpt_o         (ckpt_o),
        .restore_v_i    (restore_v_i),
        .restore_ckpt_i (restore_ckpt_i)
    );

    function automatic logic [6:0] m_ckpt();
        return {4'(m_cnt), 3'(m_tos)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [VW-1:0] link;
        link = pc_i + (compressed_i ? VW'(2) : VW'(4));
        if (reset_i) begin
            m_tos = ELS - 1;
            m_cnt = 0;
        end else if (restore_v_i) begin
            m_cnt = int'(restore_ckpt_i[6:3]);
            m_tos = int'(restore_ckpt_i[2:0]);
        end else if (scan_v_i) begin
            if (call_i && (!ret_i || m_cnt == 0)) begin
                m_tos = (m_tos + 1) % ELS;
                m_mem[m_tos] = link;
                if (m_cnt < ELS) m_cnt++;
            end else if (call_i && ret_i) begin
                m_mem[m_tos] = link;
            end else if (ret_i && !call_i && m_cnt > 0) begin
                m_tos = (m_tos + ELS - 1) % ELS;
                m_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_ret_v", 64'(ret_v_o), 64'(m_cnt != 0));
            chk("cmp_ckpt", 64'(ckpt_o), 64'(m_ckpt()));
            if (m_cnt != 0) chk("cmp_ret_addr", 64'(ret_addr_o), 64'(m_mem[m_tos]));
        end
    end

    task automatic idle();
        scan_v_i = 1'b0; call_i = 1'b0; ret_i = 1'b0; compressed_i = 1'b0;
        restore_v_i = 1'b0; reset_i = 1'b0;
    endtask

    task automatic op(input logic c, input logic r, input logic comp, input logic [VW-1:0] pc);
        scan_v_i = 1'b1; call_i = c; ret_i = r; compressed_i = comp; pc_i = pc;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk); #1;
        idle();
    endtask

    logic [6:0] cap;
    logic [6:0] saved [$];

    initial begin
        idle();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk_en = 1'b1;

        chk("reset_ret_v", 64'(ret_v_o), 64'd0);
        chk("reset_ckpt", 64'(ckpt_o), 64'h07);
        op(1'b0, 1'b1, 1'b0, VW'('h40));
        chk("empty_pop_ckpt", 64'(ckpt_o), 64'h07);

        op(1'b1, 1'b0, 1'b0, VW'('h1000));
        op(1'b1, 1'b0, 1'b1, VW'('h2002));
        chk("push2_addr", 64'(ret_addr_o), 64'h2004);
        chk("push2_cnt", 64'(ckpt_o[6:3]), 64'd2);
        op(1'b0, 1'b1, 1'b0, '0);
        chk("pop1_addr", 64'(ret_addr_o), 64'h1004);
        op(1'b0, 1'b1, 1'b0, '0);
        chk("pop2_ret_v", 64'(ret_v_o), 64'd0);

        do_reset();
        for (int i = 1; i <= 10; i++) op(1'b1, 1'b0, 1'b0, VW'(32'h100 * i));
        chk("ovf_cnt", 64'(ckpt_o[6:3]), 64'd8);
        for (int j = 1; j <= 8; j++) begin
            chk("ovf_pop_addr", 64'(ret_addr_o), 64'(32'h100 * (11 - j) + 4));
            op(1'b0, 1'b1, 1'b0, '0);
        end
        chk("ovf_drained", 64'(ret_v_o), 64'd0);
        op(1'b0, 1'b1, 1'b0, '0);
        chk("ovf_9th_pop", 64'(ckpt_o), 64'h01);

        do_reset();
        op(1'b1, 1'b0, 1'b0, VW'('h1000));
        op(1'b1, 1'b0, 1'b0, VW'('h2000));
        op(1'b1, 1'b1, 1'b0, VW'('h3000));
        chk("swap_addr", 64'(ret_addr_o), 64'h3004);
        chk("swap_cnt", 64'(ckpt_o[6:3]), 64'd2);
        op(1'b0, 1'b1, 1'b0, '0);
        chk("swap_pop_addr", 64'(ret_addr_o), 64'h1004);

        do_reset();
        op(1'b1, 1'b0, 1'b0, VW'('h500));
        op(1'b1, 1'b0, 1'b0, VW'('h600));
        cap = ckpt_o;
        chk("ckpt_capture", 64'(cap), 64'h11);
        repeat (3) op(1'b0, 1'b1, 1'b0, '0);
        op(1'b1, 1'b0, 1'b0, VW'('h700));
        restore_v_i = 1'b1; restore_ckpt_i = cap;
        op(1'b1, 1'b0, 1'b0, VW'('h800));
        chk("restore_ckpt", 64'(ckpt_o), 64'(cap));
        chk("restore_addr", 64'(ret_addr_o), 64'h604);

        op(1'b1, 1'b0, 1'b1, {VW{1'b1}});
        chk("wrap_link", 64'(ret_addr_o), 64'h1);
        reset_i = 1'b1;
        op(1'b1, 1'b0, 1'b0, VW'('h900));
        chk("reset_during_push", 64'(ckpt_o), 64'h07);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                do_reset();
            end else if (sel < 10 && saved.size() > 0) begin
                restore_v_i = 1'b1;
                restore_ckpt_i = saved[$urandom_range(0, saved.size() - 1)];
                op(1'($urandom), 1'($urandom), 1'($urandom), VW'({$urandom, $urandom}));
            end else if (sel < 18) begin
                saved.push_back(m_ckpt());
                if (saved.size() > 8) void'(saved.pop_front());
                @(posedge clk); #1;
            end else begin
                logic [VW-1:0] pc;
                pc = (sel < 22) ? {VW{1'b1}} : VW'({$urandom, $urandom});
                scan_v_i = 1'($urandom_range(0, 3) != 0);
                call_i = 1'($urandom); ret_i = 1'($urandom);
                compressed_i = 1'($urandom); pc_i = pc;
                @(posedge clk); #1;
                idle();
            end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bp_fe_ras.md
# bp_fe_ras

Return address stack for the front end. Consumes the per-instruction scan classification (call / ret / compressed) produced by the instruction scanner, pushes the link address on calls, and supplies a predicted return target for returns. Sits beside the BTB/BHT in the PC-generation stage. Supports checkpoint/restore of its pointer state so the FE can roll back on redirects.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies vaddr_width_p.
- ras_els_p, 8: number of entries; power of two, >= 2.
- ptr_width_lp (local), `BSG_SAFE_CLOG2(ras_els_p)`: top-of-stack (TOS) index width.
- cnt_width_lp (local), `BSG_SAFE_CLOG2(ras_els_p+1)`: occupancy count width.
- ckpt_width_lp (local), cnt_width_lp + ptr_width_lp: checkpoint width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- scan_v_i  in  1  scan fields below are valid this cycle.
- call_i  in  1  scanned instruction is a call.
- ret_i  in  1  scanned instruction is a return.
- compressed_i  in  1  scanned instruction is 16-bit.
- pc_i  in  vaddr_width_p  PC of the scanned instruction.
- ret_v_o  out  1  stack non-empty; ret_addr_o is meaningful.
- ret_addr_o  out  vaddr_width_p  entry at TOS (predicted return target).
- ckpt_o  out  ckpt_width_lp  {count, tos} state at the start of the current cycle.
- restore_v_i  in  1  load state from restore_ckpt_i.
- restore_ckpt_i  in  ckpt_width_lp  checkpoint previously taken from ckpt_o.

## Operation
- State: entry array mem[ras_els_p] (vaddr_width_p each), tos (ptr_width_lp), count (cnt_width_lp).
- Link address = pc_i + (compressed_i ? 2 : 4), truncated to vaddr_width_p (wraps modulo 2^vaddr_width_p).
- Per cycle, in priority order:
  - restore_v_i: {count, tos} <= restore_ckpt_i; no array write; scan inputs ignored.
  - scan_v_i & call_i & ~ret_i (push): mem[tos+1] <= link; tos <= tos+1 (wraps); count <= min(count+1, ras_els_p).
  - scan_v_i & ret_i & ~call_i (pop): if count != 0 then tos <= tos-1 (wraps), count <= count-1; if count == 0, no state change.
  - scan_v_i & call_i & ret_i (pop-then-push, coroutine swap): if count != 0, mem[tos] <= link, tos and count unchanged; if count == 0, behaves as push.
  - otherwise: hold.
- Overflow: push at count == ras_els_p overwrites the oldest entry; count stays saturated.
- Restore recovers pointers only; entries overwritten since the checkpoint stay overwritten (accepted prediction loss, never a functional error).
- ret_v_o = (count != 0); ret_addr_o = mem[tos], combinational read.

## Timing
- Reset: tos <= ras_els_p-1 (first push lands at index 0), count <= 0; array not reset. Outputs after reset: ret_v_o = 0, ckpt_o = {0, ras_els_p-1}; ret_addr_o is don't-care.
- Push/pop/restore take effect at the next edge; ret_addr_o/ret_v_o/ckpt_o reflect it the following cycle (1-cycle latency, no bypass).
- Prediction for a ret in cycle N uses pre-update ret_addr_o in cycle N.
- reset_i overrides restore_v_i and scan_v_i in the same cycle.
- Input fields with scan_v_i = 0 are don't-care; no X propagation into state.

## Structure
- Add `declare_bp_fe_ras_ckpt_s(ptr_width, cnt_width)` struct macro ({cnt, tos}) and width macro to bp_fe_defines.svh.
- Entry storage: bsg_mem_1r1w (ras_els_p x vaddr_width_p, async read, sync write); no other sub-module.

## Test plan
- Reset, no scans -> ret_v_o = 0, ckpt_o = {0, 7}; single ret scan -> state unchanged.
- Push pc 0x1000 (non-compressed), then pc 0x2002 (compressed) -> ret_addr_o = 0x2004, count 2; pop -> ret_addr_o = 0x1004; pop -> ret_v_o = 0.
- 10 pushes (pc = 0x100*i, i = 1..10) with ras_els_p = 8 -> count saturates at 8; 8 pops yield 0xA04 down to 0x304; 9th pop is a no-op.
- Push 0x1000, push 0x2000; call+ret with pc 0x3000 -> ret_addr_o = 0x3004, count 2; pop -> 0x1004.
- Capture ckpt_o after 2 pushes, do 3 pops and 1 push, assert restore_v_i with a simultaneous push -> push ignored, ckpt_o equals capture next cycle.
- pc_i = all ones, compressed -> link wraps to 0x1; reset asserted during push -> count = 0.
